// File: rtl/pipe_pkg.sv
// Shared pipeline constants: MEM-stage FSM encoding, default widths,
// and the hard-wired zero register index.
package pipe_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [3:0] REG_ZERO = 4'd0;

endpackage

// File: rtl/mem_req_fsm.sv
// MEM-stage request FSM: IDLE/BUSY/DONE sequencing of the data-memory
// handshake plus request and pipeline-stall generation.
module mem_req_fsm
    import pipe_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       acc,
    input  logic       dmem_ready,
    output logic [1:0] state,
    output logic       dmem_req,
    output logic       mem_stall
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       active;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (acc) state_d = dmem_ready ? S_DONE : S_BUSY;
            S_BUSY:  if (dmem_ready) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Gated by rst so an aborted request drops at once, even with acc high
    assign active    = ((state_q == S_IDLE) & acc) | (state_q == S_BUSY);
    assign dmem_req  = rst & active;
    assign mem_stall = rst & active;
    assign state     = state_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: data-memory handshake, request latching, load capture
// and stall counting. Define MEM_FWD_EN for WB->MEM store-data forwarding.
module mem_access_stage
    import pipe_pkg::*;
#(
    parameter int ADDR_W = pipe_pkg::ADDR_W,
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              M_memRead,
    input  logic              M_memWrite,
    input  logic [ADDR_W-1:0] M_aluOut,
    input  logic [DATA_W-1:0] M_regData2,
    input  logic [3:0]        M_Rt,
    input  logic              W_regWrite,
    input  logic [3:0]        W_Rd,
    input  logic [DATA_W-1:0] W_wbData,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [DATA_W-1:0] M_memData,
    output logic              mem_stall,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              acc;
    logic [1:0]        state;
    logic              idle;
    logic              busy;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] wdata_in;
    logic              latch;
    logic              capture;
    logic              unused_in;

    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mdata_q, mdata_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    mem_req_fsm u_fsm (
        .clk        (clk),
        .rst        (rst),
        .acc        (acc),
        .dmem_ready (dmem_ready),
        .state      (state),
        .dmem_req   (dmem_req),
        .mem_stall  (mem_stall)
    );

    assign acc     = M_memRead | M_memWrite;
    assign idle    = (state == S_IDLE);
    assign busy    = (state == S_BUSY);
    assign addr_in = {M_aluOut[ADDR_W-1:1], 1'b0};

`ifdef MEM_FWD_EN
    logic fwd_hit;
    assign fwd_hit   = W_regWrite & (W_Rd == M_Rt) & (W_Rd != REG_ZERO);
    assign wdata_in  = fwd_hit ? W_wbData : M_regData2;
    assign unused_in = M_aluOut[0];
`else
    assign wdata_in  = M_regData2;
    assign unused_in = ^{W_regWrite, W_Rd, W_wbData, M_Rt, M_aluOut[0]};
`endif

    // A write wins when both read and write are requested
    assign latch   = idle & acc & ~dmem_ready;
    assign capture = dmem_ready
                   & ((idle & acc & ~M_memWrite) | (busy & ~we_q));

    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        mdata_d = mdata_q;
        cnt_d   = cnt_q;
        if (latch) begin
            addr_d  = addr_in;
            we_d    = M_memWrite;
            wdata_d = wdata_in;
        end
        if (capture)
            mdata_d = dmem_rdata;
        if (mem_stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            mdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            mdata_q <= mdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // While BUSY the latched request drives memory, isolating input changes
    assign dmem_we    = busy ? we_q    : M_memWrite;
    assign dmem_addr  = busy ? addr_q  : addr_in;
    assign dmem_wdata = busy ? wdata_q : wdata_in;
    assign M_memData  = mdata_q;
    assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
// Forwarding expectations follow MEM_FWD_EN.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        M_memRead;
    logic        M_memWrite;
    logic [15:0] M_aluOut;
    logic [15:0] M_regData2;
    logic [3:0]  M_Rt;
    logic        W_regWrite;
    logic [3:0]  W_Rd;
    logic [15:0] W_wbData;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ready;
    logic [15:0] M_memData;
    logic        mem_stall;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    mem_access_stage dut (
        .clk        (clk),
        .rst        (rst),
        .M_memRead  (M_memRead),
        .M_memWrite (M_memWrite),
        .M_aluOut   (M_aluOut),
        .M_regData2 (M_regData2),
        .M_Rt       (M_Rt),
        .W_regWrite (W_regWrite),
        .W_Rd       (W_Rd),
        .W_wbData   (W_wbData),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .M_memData  (M_memData),
        .mem_stall  (mem_stall),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        M_memRead = 0; M_memWrite = 0;
        M_aluOut = '0; M_regData2 = '0; M_Rt = '0;
        W_regWrite = 0; W_Rd = '0; W_wbData = '0;
        dmem_rdata = '0; dmem_ready = 0;
        #2;
        chk("rst_req", dmem_req, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_mdata", M_memData, 0);
        chk("rst_cnt", stall_cnt, 0);
        tick();
        rst = 1'b1;

        // Load 0x0010, ready with req
        M_memRead = 1; M_aluOut = 16'h0010;
        dmem_ready = 1; dmem_rdata = 16'hBEEF;
        #2;
        chk("ld1_req", dmem_req, 1);
        chk("ld1_stall", mem_stall, 1);
        chk("ld1_we", dmem_we, 0);
        chk("ld1_addr", dmem_addr, 16'h0010);
        tick();
        dmem_ready = 0; dmem_rdata = 16'h0000;
        #2;
        chk("ld1_done_stall", mem_stall, 0);
        chk("ld1_done_req", dmem_req, 0);
        chk("ld1_mdata", M_memData, 16'hBEEF);
        chk("ld1_cnt", stall_cnt, 1);
        tick();
        M_memRead = 0;
        #2;
        chk("idle_stall", mem_stall, 0);
        rst = 1'b0;
        #1;
        chk("rst2_cnt", stall_cnt, 0);
        chk("rst2_mdata", M_memData, 0);
        rst = 1'b1;

        // Store 0x1234 to 0x0023, ready 3 cycles late
        tick();
        M_memWrite = 1; M_aluOut = 16'h0023; M_regData2 = 16'h1234;
        #2;
        chk("st_req", dmem_req, 1);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 16'h0022);
        chk("st_wdata", dmem_wdata, 16'h1234);
        for (int i = 0; i < 2; i++) begin
            tick();
            M_memWrite = 0; M_memRead = 1;
            M_aluOut = 16'hFFF0 + 16'(i);
            M_regData2 = 16'hDEAD ^ 16'(i);
            dmem_rdata = 16'h5A5A;
            #2;
            chk("st_wait_we", dmem_we, 1);
            chk("st_wait_addr", dmem_addr, 16'h0022);
            chk("st_wait_wdata", dmem_wdata, 16'h1234);
            chk("st_wait_stall", mem_stall, 1);
        end
        tick();
        dmem_ready = 1;
        #2;
        chk("st_rdy_addr", dmem_addr, 16'h0022);
        chk("st_rdy_we", dmem_we, 1);
        chk("st_rdy_stall", mem_stall, 1);
        tick();
        dmem_ready = 0; M_memRead = 0;
        #2;
        chk("st_done_stall", mem_stall, 0);
        chk("st_cnt", stall_cnt, 4);
        chk("st_mdata", M_memData, 0);

        // Store-data forwarding from WB
        tick();
        M_memWrite = 1; M_aluOut = 16'h0040; M_Rt = 4'd5;
        W_Rd = 4'd5; W_regWrite = 1;
        W_wbData = 16'hAAAA; M_regData2 = 16'h5555;
        dmem_ready = 1;
        #2;
`ifdef MEM_FWD_EN
        chk("fwd_hit", dmem_wdata, 16'hAAAA);
`else
        chk("fwd_off", dmem_wdata, 16'h5555);
`endif
        tick();
        dmem_ready = 0;
        #2;
        chk("fwd_done", mem_stall, 0);
        tick();
        W_Rd = 4'd0; dmem_ready = 1;
        #2;
        chk("fwd_r0", dmem_wdata, 16'h5555);
        tick();
        dmem_ready = 0;
        #2;
        chk("fwd_mdata", M_memData, 0);
        chk("fwd_cnt", stall_cnt, 6);

        // Load, ALU op, late load
        tick();
        M_memWrite = 0; W_regWrite = 0;
        M_memRead = 1; M_aluOut = 16'h0050;
        dmem_rdata = 16'h1111; dmem_ready = 1;
        #2;
        chk("b2b_ld1_stall", mem_stall, 1);
        tick();
        dmem_ready = 0;
        #2;
        chk("b2b_ld1_mdata", M_memData, 16'h1111);
        chk("b2b_ld1_done", mem_stall, 0);
        tick();
        M_memRead = 0;
        #2;
        chk("b2b_alu_stall", mem_stall, 0);
        chk("b2b_alu_req", dmem_req, 0);
        tick();
        M_memRead = 1; M_aluOut = 16'h0052; dmem_rdata = 16'h9999;
        #2;
        chk("b2b_ld2_stall0", mem_stall, 1);
        chk("b2b_ld2_hold0", M_memData, 16'h1111);
        tick();
        dmem_ready = 1; dmem_rdata = 16'h2222;
        #2;
        chk("b2b_ld2_stall1", mem_stall, 1);
        chk("b2b_ld2_hold1", M_memData, 16'h1111);
        tick();
        dmem_ready = 0;
        #2;
        chk("b2b_ld2_mdata", M_memData, 16'h2222);
        chk("b2b_ld2_done", mem_stall, 0);
        chk("b2b_cnt", stall_cnt, 9);

        // Read and write together: treated as a write
        tick();
        M_memRead = 1; M_memWrite = 1; M_aluOut = 16'h0060;
        M_regData2 = 16'h4321; dmem_rdata = 16'h7777; dmem_ready = 1;
        #2;
        chk("both_we", dmem_we, 1);
        chk("both_req", dmem_req, 1);
        tick();
        dmem_ready = 0;
        #2;
        chk("both_mdata", M_memData, 16'h2222);
        chk("both_cnt", stall_cnt, 10);

        // Reset while BUSY
        tick();
        M_memWrite = 0; M_memRead = 1; M_aluOut = 16'h0070;
        #2;
        chk("rb_req0", dmem_req, 1);
        tick();
        #2;
        chk("rb_busy_req", dmem_req, 1);
        chk("rb_busy_cnt", stall_cnt, 11);
        rst = 1'b0;
        #1;
        chk("rb_req", dmem_req, 0);
        chk("rb_stall", mem_stall, 0);
        chk("rb_mdata", M_memData, 0);
        chk("rb_cnt", stall_cnt, 0);
        M_aluOut = 16'h0031;
        #1;
        chk("rb_idle_addr", dmem_addr, 16'h0030);
        M_memRead = 0;
        rst = 1'b1;
        tick();
        M_memRead = 1; M_aluOut = 16'h0080;
        dmem_rdata = 16'hABCD; dmem_ready = 1;
        #2;
        chk("post_req", dmem_req, 1);
        tick();
        dmem_ready = 0;
        #2;
        chk("post_mdata", M_memData, 16'hABCD);
        chk("post_stall", mem_stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the 5-stage pipeline. It sits between the X/M pipeline register and the M/W pipeline register. It consumes the registered MEM-stage control, address and store data, and runs a request/ready handshake with the data memory or cache. It freezes the upstream pipeline with a stall while an access is outstanding, and presents registered load data to the M/W register.

## Interface
Parameters:
- `ADDR_W`, default 16: address width.
- `DATA_W`, default 16: data word width.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `M_memRead`  in  1  load in MEM stage.
- `M_memWrite`  in  1  store in MEM stage.
- `M_aluOut`  in  ADDR_W  effective byte address.
- `M_regData2`  in  DATA_W  store data from register file.
- `M_Rt`  in  4  store-data source register.
- `W_regWrite`  in  1  WB-stage instruction writes the register file.
- `W_Rd`  in  4  WB-stage destination register.
- `W_wbData`  in  DATA_W  WB-stage writeback value.
- `dmem_req`  out  1  access request.
- `dmem_we`  out  1  1 = write, 0 = read.
- `dmem_addr`  out  ADDR_W  word-aligned address.
- `dmem_wdata`  out  DATA_W  store data.
- `dmem_rdata`  in  DATA_W  read data, valid when `dmem_ready` is high.
- `dmem_ready`  in  1  access complete this cycle.
- `M_memData`  out  DATA_W  registered load result, to M/W register.
- `mem_stall`  out  1  freeze PC, F/D, D/X, X/M and M/W registers (`wen` = `~mem_stall`).
- `stall_cnt`  out  CNT_W  saturating count of cycles with `mem_stall` high.

## Operation
- Access condition: `acc = M_memRead | M_memWrite`. If both are high, the access is a write.
- Address: `dmem_addr = {M_aluOut[ADDR_W-1:1], 1'b0}`. Bit 0 is ignored.
- FSM states:
  - IDLE:
    - `acc & dmem_ready` → DONE. If it is a read, capture `dmem_rdata` into `M_memData`.
    - `acc & ~dmem_ready` → BUSY. Latch addr/we/wdata into request registers.
    - `~acc` → stay in IDLE.
  - BUSY:
    - `dmem_ready` → DONE, capturing read data.
    - Otherwise stay in BUSY.
  - DONE:
    - Always → IDLE. The pipeline advances at the end of this cycle, so the instruction is never re-issued.
- Outputs:
  - `dmem_req = (IDLE & acc) | BUSY`.
  - In IDLE, `dmem_we`/`dmem_addr`/`dmem_wdata` are combinational from the inputs. In BUSY they come from the latched request registers and are stable until `dmem_ready`.
  - `mem_stall = (IDLE & acc) | BUSY`. It is low in DONE and for non-memory instructions.
- `M_memData` updates only on a read completion and otherwise holds its value. Stores never modify it.
- `stall_cnt` increments each cycle `mem_stall` = 1 and saturates at all-ones.
- `dmem_ready` is ignored whenever `dmem_req` = 0.

## Timing
- Non-memory instruction: 0 stall cycles.
- Memory instruction with ready in the same cycle as req: stalled 1 cycle, in DONE in the next cycle, 2 cycles total in MEM.
- Memory instruction with ready N cycles after req: N+1 stall cycles plus the DONE cycle.
- `M_memData` is valid from the cycle after the `dmem_ready` edge, in DONE, when M/W captures it.
- Reset values: FSM=IDLE, `M_memData`=0, request registers=0, `stall_cnt`=0. Outputs with `acc`=0: `dmem_req`=0, `mem_stall`=0.
- Reset asserted mid-access (BUSY): the request is abandoned immediately and `dmem_req` drops asynchronously. Memory must tolerate an aborted request.
- Inputs change while in BUSY: ignored, because the latched registers drive memory.

## Configuration
- `MEM_FWD_EN` defined: store-data WB→MEM forwarding.
  - `dmem_wdata` source = `W_wbData` when `W_regWrite & (W_Rd == M_Rt) & (W_Rd != 0)`, else `M_regData2`.
  - The selection is evaluated in IDLE and latched on entry to BUSY.
- `MEM_FWD_EN` undefined: `dmem_wdata` = `M_regData2` always. The `W_*` inputs are unused.

## Structure
- Shared package `pipe_pkg`:
  - FSM state encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10.
  - Width constants `ADDR_W`/`DATA_W`.
  - Register-zero constant.
- One sub-module, `mem_req_fsm`: state register, next-state logic, `dmem_req`/`mem_stall` generation. The datapath latches, forwarding mux and counter stay in the top module.

## Test plan
- Load from 0x0010, with `dmem_ready` high in the same cycle as req and `rdata` = 0xBEEF → `mem_stall` high 1 cycle, DONE next cycle, `M_memData` = 0xBEEF.
- Store to 0x0023 with data 0x1234, `dmem_ready` delayed 3 cycles, inputs toggled during the wait → `dmem_addr` = 0x0022, `dmem_wdata` = 0x1234 and `dmem_we` = 1 stable across the wait. `mem_stall` high 4 cycles, `stall_cnt` = 4.
- With `MEM_FWD_EN`: `M_Rt` = 5, `W_Rd` = 5, `W_regWrite` = 1, `W_wbData` = 0xAAAA, `M_regData2` = 0x5555 → `dmem_wdata` = 0xAAAA. Repeat with `W_Rd` = 0 → 0x5555.
- Back-to-back load then ALU op, then load (ready 1 cycle late) → ALU op passes with no stall. Second load stalls 2 cycles. `M_memData` holds the first value until the second completes.
- `rst` low while in BUSY with `M_memRead` = 1 → `dmem_req` = 0 immediately, FSM IDLE, `M_memData` = 0, `stall_cnt` = 0.
- Both `M_memRead` and `M_memWrite` high → `dmem_we` = 1 and `M_memData` unchanged.
